vga_fb_arbiter: RTL and testbench

Frame-buffer port controller on the `sys_clk` side of the line-buffer VGA core. It shares one single-port, fixed-latency SRAM between two requesters:
- a raster-order display fetch engine, which produces the `{frame_start, rgb}` stream consumed by the core's `line_buffer_data/vld/rdy` input;
- a host read/write port used by the drawing logic.

Display fetch has priority, bounded by a host-starvation guard.

---
 rtl/vga_fb_arbiter_pkg.sv | 15 +
 rtl/vga_fb_fifo.sv | 57 +++++
 rtl/vga_fb_arbiter.sv | 142 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and frame geometry for the frame-buffer arbiter.
// The display constants mirror the VGA core's timing header.
package vga_fb_arbiter_pkg;

   localparam int H_DISPLAY    = 640;
   localparam int V_DISPLAY    = 480;
   localparam int FRAME_PIXELS = H_DISPLAY * V_DISPLAY;

   typedef struct packed {
      logic valid;
      logic isHost;
      logic frameStart;
   } rd_tag_t;

endpackage

// File: rtl/vga_fb_fifo.sv
// Synchronous FIFO holding display words between SRAM returns and the line buffer.
module vga_fb_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, rdPtr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush, doPop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign count  = count_q;
   assign rdata  = mem_q[rdPtr_q];
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   always_comb begin
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + CW'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata;
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one fixed-latency SRAM between the raster fetch engine and the host port.
// Fetch has priority; a burst counter guarantees the host a slot every BURST_MAX fetches.
module vga_fb_arbiter
   import vga_fb_arbiter_pkg::*;
#(
   parameter int RGB_SIZE   = 12,
   parameter int AW         = 19,
   parameter int READ_LAT   = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                fetch_en,
   input  logic                host_req,
   input  logic                host_we,
   input  logic [AW-1:0]       host_addr,
   input  logic [RGB_SIZE-1:0] host_wdata,
   output logic                host_rdy,
   output logic [RGB_SIZE-1:0] host_rdata,
   output logic                host_rvld,
   output logic                sram_ce,
   output logic                sram_we,
   output logic [AW-1:0]       sram_addr,
   output logic [RGB_SIZE-1:0] sram_wdata,
   input  logic [RGB_SIZE-1:0] sram_rdata,
   output logic [RGB_SIZE:0]   line_buffer_data,
   output logic                line_buffer_vld,
   input  logic                line_buffer_rdy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [AW-1:0] FA_LAST = AW'(FRAME_PIXELS - 1);

   logic [AW-1:0]       fa_q, fa_d;
   logic [CW-1:0]       inflight_q, inflight_d;
   logic [BW-1:0]       burstCnt_q, burstCnt_d;
   rd_tag_t             tag_q [READ_LAT+1];
   rd_tag_t             returnTag;
   logic                sramCe_q, sramWe_q;
   logic [AW-1:0]       sramAddr_q;
   logic [RGB_SIZE-1:0] sramWdata_q;
   logic [RGB_SIZE-1:0] hostRdata_q;
   logic                hostRvld_q;

   logic [CW-1:0]       fifoCount;
   logic                fifoEmpty, fifoFull, fifoPush, fifoPop;
   logic                fetchWant, burstHit, grantHost, grantFetch;

   // Credits cover both words already queued and reads still in the SRAM pipe.
   assign fetchWant  = fetch_en && !sys_rst &&
                       (({1'b0, inflight_q} + {1'b0, fifoCount}) < (CW+1)'(FIFO_DEPTH));
   assign burstHit   = (burstCnt_q == BW'(BURST_MAX));
   assign grantHost  = host_req && !sys_rst && (!fetchWant || burstHit);
   assign grantFetch = fetchWant && !grantHost;
   assign host_rdy   = grantHost;

   assign returnTag  = tag_q[READ_LAT];
   assign fifoPush   = returnTag.valid && !returnTag.isHost && !fifoFull;
   assign fifoPop    = !fifoEmpty && line_buffer_rdy;

   assign sram_ce    = sramCe_q;
   assign sram_we    = sramWe_q;
   assign sram_addr  = sramAddr_q;
   assign sram_wdata = sramWdata_q;
   assign host_rdata = hostRdata_q;
   assign host_rvld  = hostRvld_q;
   assign line_buffer_vld = !fifoEmpty;

   always_comb begin
      fa_d = fa_q;
      if (!fetch_en) begin
         fa_d = '0;
      end else if (grantFetch) begin
         fa_d = (fa_q == FA_LAST) ? '0 : fa_q + AW'(1);
      end
   end

   always_comb begin
      inflight_d = inflight_q + CW'(grantFetch) - CW'(fifoPush);
   end

   always_comb begin
      burstCnt_d = burstCnt_q;
      if (grantHost || !host_req) begin
         burstCnt_d = '0;
      end else if (grantFetch && !burstHit) begin
         burstCnt_d = burstCnt_q + BW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         fa_q        <= '0;
         inflight_q  <= '0;
         burstCnt_q  <= '0;
         sramCe_q    <= 1'b0;
         sramWe_q    <= 1'b0;
         sramAddr_q  <= '0;
         sramWdata_q <= '0;
         hostRdata_q <= '0;
         hostRvld_q  <= 1'b0;
         for (int i = 0; i <= READ_LAT; i++) tag_q[i] <= '0;
      end else begin
         fa_q       <= fa_d;
         inflight_q <= inflight_d;
         burstCnt_q <= burstCnt_d;
         sramCe_q   <= grantHost || grantFetch;
         sramWe_q   <= grantHost && host_we;
         if (grantHost) begin
            sramAddr_q <= host_addr;
         end else if (grantFetch) begin
            sramAddr_q <= fa_q;
         end
         if (grantHost && host_we) sramWdata_q <= host_wdata;
         // Tag stage READ_LAT lines up with the cycle sram_rdata is valid.
         tag_q[0] <= '{valid:      (grantHost && !host_we) || grantFetch,
                       isHost:     grantHost,
                       frameStart: grantFetch && (fa_q == '0)};
         for (int i = 1; i <= READ_LAT; i++) tag_q[i] <= tag_q[i-1];
         hostRvld_q <= returnTag.valid && returnTag.isHost;
         if (returnTag.valid && returnTag.isHost) hostRdata_q <= sram_rdata;
      end
   end

   vga_fb_fifo #(
      .WIDTH (RGB_SIZE + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (fifoPush),
      .pop   (fifoPop),
      .wdata ({returnTag.frameStart, sram_rdata}),
      .rdata (line_buffer_data),
      .count (fifoCount),
      .empty (fifoEmpty),
      .full  (fifoFull)
   );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with an SRAM model and a frame-order stream reference.
module tb_vga_fb_arbiter;
   import vga_fb_arbiter_pkg::*;

   localparam int RGB_SIZE   = 12;
   localparam int AW         = 19;
   localparam int READ_LAT   = 2;
   localparam int FIFO_DEPTH = 8;
   localparam int BURST_MAX  = 4;

   logic                sys_clk = 1'b0;
   logic                sys_rst;
   logic                fetch_en;
   logic                host_req, host_we;
   logic [AW-1:0]       host_addr;
   logic [RGB_SIZE-1:0] host_wdata;
   logic                host_rdy;
   logic [RGB_SIZE-1:0] host_rdata;
   logic                host_rvld;
   logic                sram_ce, sram_we;
   logic [AW-1:0]       sram_addr;
   logic [RGB_SIZE-1:0] sram_wdata;
   logic [RGB_SIZE-1:0] sram_rdata;
   logic [RGB_SIZE:0]   line_buffer_data;
   logic                line_buffer_vld;
   logic                line_buffer_rdy;

   always #5 sys_clk = ~sys_clk;

   vga_fb_arbiter #(
      .RGB_SIZE(RGB_SIZE), .AW(AW), .READ_LAT(READ_LAT),
      .FIFO_DEPTH(FIFO_DEPTH), .BURST_MAX(BURST_MAX)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .fetch_en(fetch_en),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdy(host_rdy), .host_rdata(host_rdata),
      .host_rvld(host_rvld), .sram_ce(sram_ce), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .line_buffer_data(line_buffer_data), .line_buffer_vld(line_buffer_vld),
      .line_buffer_rdy(line_buffer_rdy)
   );

   int compared = 0, mismatched = 0, cyc = 0;
   int ceCount = 0, readCount = 0, streamWords = 0, expAddr = 0;
   int rdBase = 0, wdBase = 0;
   logic [11:0] seedMask;
   logic [RGB_SIZE-1:0] sramMem [int];
   logic [RGB_SIZE-1:0] refMem  [int];
   logic [RGB_SIZE-1:0] rdPipe  [READ_LAT];

   function automatic logic [RGB_SIZE-1:0] baseWord(int a);
      return 12'(a) ^ 12'(a >>> 6) ^ seedMask;
   endfunction

   function automatic logic [RGB_SIZE-1:0] sramRead(int a);
      return sramMem.exists(a) ? sramMem[a] : baseWord(a);
   endfunction

   function automatic logic [RGB_SIZE-1:0] refRead(int a);
      return refMem.exists(a) ? refMem[a] : baseWord(a);
   endfunction

   always @(posedge sys_clk) cyc <= cyc + 1;

   // SRAM model: data for a read registered in cycle c is presented in c+READ_LAT.
   always @(posedge sys_clk) begin
      if (sram_ce && sram_we) sramMem[int'(sram_addr)] = sram_wdata;
      for (int i = READ_LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
      rdPipe[0] <= (sram_ce && !sram_we) ? sramRead(int'(sram_addr)) : '0;
   end
   assign sram_rdata = rdPipe[READ_LAT-1];

   // Stream reference: words leave in raster order, frame_start only on address 0.
   always @(negedge sys_clk) begin
      logic [RGB_SIZE:0] expWord;
      if (sram_ce) ceCount++;
      if (sram_ce && !sram_we) readCount++;
      if (!sys_rst && line_buffer_vld && line_buffer_rdy) begin
         expWord = {(expAddr == 0), refRead(expAddr)};
         compared++;
         if (line_buffer_data !== expWord) begin
            mismatched++;
            $display("[TB] FAIL stream word %0d: got %h expected %h", expAddr, line_buffer_data, expWord);
         end
         streamWords++;
         expAddr = (expAddr + 1) % FRAME_PIXELS;
      end
   end

   task automatic nextCycle;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] obs [8];
      string nm [8];
      sys_rst = 1'b1; fetch_en = 1'b1; host_req = 1'b1; host_we = 1'b1;
      host_addr = 19'h1234; host_wdata = 12'hFFF; line_buffer_rdy = 1'b1;
      repeat (3) nextCycle;
      @(negedge sys_clk);
      obs = '{32'(sram_ce), 32'(sram_we), 32'(sram_addr), 32'(sram_wdata),
              32'(host_rdy), 32'(host_rvld), 32'(host_rdata), 32'(line_buffer_vld)};
      nm  = '{"sram_ce", "sram_we", "sram_addr", "sram_wdata",
              "host_rdy", "host_rvld", "host_rdata", "line_buffer_vld"};
      for (int i = 0; i < 8; i++) begin
         compared++;
         if (obs[i] !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset %s: got %0h expected 0", nm[i], obs[i]);
         end
      end
      nextCycle;
      sys_rst = 1'b0; fetch_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
      repeat (2) nextCycle;
   endtask

   task automatic test_free_running;
      int t0, firstVld, c0, w0;
      expAddr = 0; line_buffer_rdy = 1'b1; host_req = 1'b0;
      fetch_en = 1'b1;
      t0 = cyc; firstVld = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         if (line_buffer_vld && firstVld < 0) firstVld = cyc;
         nextCycle;
      end
      compared++;
      if (firstVld != t0 + 2 + READ_LAT) begin
         mismatched++;
         $display("[TB] FAIL first_word_latency: got cycle %0d expected %0d", firstVld, t0 + 2 + READ_LAT);
      end
      repeat (20) nextCycle;
      c0 = ceCount;
      repeat (100) nextCycle;
      compared++;
      if (ceCount - c0 != 100) begin
         mismatched++;
         $display("[TB] FAIL back_to_back_fetch: got %0d reads in 100 cycles expected 100", ceCount - c0);
      end
      w0 = streamWords;
      for (int i = 0; i < 300; i++) begin
         line_buffer_rdy = ($urandom_range(0, 3) != 0);
         nextCycle;
      end
      line_buffer_rdy = 1'b1;
      compared++;
      if (streamWords - w0 < 150) begin
         mismatched++;
         $display("[TB] FAIL random_rdy_throughput: got %0d words expected at least 150", streamWords - w0);
      end
   endtask

   task automatic test_backpressure;
      int w0;
      fetch_en = 1'b0; line_buffer_rdy = 1'b1;
      repeat (20) nextCycle;
      line_buffer_rdy = 1'b0; expAddr = 0;
      rdBase = readCount; wdBase = streamWords;
      fetch_en = 1'b1;
      repeat (50) nextCycle;
      compared++;
      if (readCount - rdBase != FIFO_DEPTH) begin
         mismatched++;
         $display("[TB] FAIL backpressure_reads: got %0d expected %0d", readCount - rdBase, FIFO_DEPTH);
      end
      @(negedge sys_clk);
      compared++;
      if (line_buffer_vld !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL backpressure_vld: got %b expected 1", line_buffer_vld);
      end
      nextCycle;
      w0 = streamWords;
      line_buffer_rdy = 1'b1;
      repeat (8) nextCycle;
      compared++;
      if (streamWords - w0 != 8) begin
         mismatched++;
         $display("[TB] FAIL release_pops: got %0d expected 8", streamWords - w0);
      end
      repeat (40) nextCycle;
      compared++;
      if (streamWords - w0 != 48) begin
         mismatched++;
         $display("[TB] FAIL fetch_resume: got %0d words expected 48", streamWords - w0);
      end
   endtask

   task automatic test_fetch_disable;
      int c0, w0;
      bit seen;
      for (int i = 0; i < 3000 && expAddr < 1000; i++) nextCycle;
      compared++;
      if (expAddr < 1000) begin
         mismatched++;
         $display("[TB] FAIL reach_addr_1000: got %0d expected 1000", expAddr);
      end
      fetch_en = 1'b0;
      nextCycle;
      c0 = ceCount;
      repeat (30) nextCycle;
      compared++;
      if (ceCount - c0 != 0) begin
         mismatched++;
         $display("[TB] FAIL no_grant_after_disable: got %0d accesses expected 0", ceCount - c0);
      end
      compared++;
      if (streamWords - wdBase != readCount - rdBase) begin
         mismatched++;
         $display("[TB] FAIL inflight_delivered: got %0d words expected %0d", streamWords - wdBase, readCount - rdBase);
      end
      expAddr = 0; w0 = streamWords; seen = 1'b0;
      fetch_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge sys_clk);
         if (line_buffer_vld && !seen) begin
            seen = 1'b1;
            compared++;
            if (line_buffer_data !== {1'b1, refRead(0)}) begin
               mismatched++;
               $display("[TB] FAIL restart_word: got %h expected %h", line_buffer_data, {1'b1, refRead(0)});
            end
         end
         nextCycle;
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("[TB] FAIL restart_timeout: got no word expected one within 12 cycles");
      end
   endtask

   task automatic test_host_starvation;
      int expCyc[$];
      int runLen = 0, hostGrants = 0;
      bit hostPrev = 1'b0, expRv;
      logic [RGB_SIZE-1:0] expData;
      expData = refRead(32'h100);
      host_we = 1'b0; host_addr = 19'h100; host_wdata = '0;
      host_req = 1'b1; line_buffer_rdy = 1'b1;
      for (int i = 0; i < 160; i++) begin
         if (i == 150) host_req = 1'b0;
         @(negedge sys_clk);
         if (i > 0 && i < 150 && sram_ce && !sram_we && !hostPrev) runLen++;
         if (host_rdy) begin
            compared++;
            if (runLen > BURST_MAX) begin
               mismatched++;
               $display("[TB] FAIL burst_guard: got %0d fetch grants expected at most %0d", runLen, BURST_MAX);
            end
            runLen = 0; hostGrants++;
            expCyc.push_back(cyc + 2 + READ_LAT);
         end
         hostPrev = host_rdy;
         expRv = (expCyc.size() > 0) && (expCyc[0] == cyc);
         compared++;
         if (host_rvld !== expRv) begin
            mismatched++;
            $display("[TB] FAIL host_rvld_timing cycle %0d: got %b expected %b", cyc, host_rvld, expRv);
         end
         if (expRv) begin
            void'(expCyc.pop_front());
            compared++;
            if (host_rdata !== expData) begin
               mismatched++;
               $display("[TB] FAIL host_rdata_0x100: got %h expected %h", host_rdata, expData);
            end
         end
         nextCycle;
      end
      compared++;
      if (hostGrants < 150 / (BURST_MAX + 1) - 2) begin
         mismatched++;
         $display("[TB] FAIL host_grant_count: got %0d expected at least %0d", hostGrants, 150 / (BURST_MAX + 1) - 2);
      end
   endtask

   task automatic test_host_write_read;
      bit accepted;
      int tg, rvCyc, w0;
      fetch_en = 1'b0; line_buffer_rdy = 1'b1;
      repeat (20) nextCycle;
      w0 = streamWords;
      for (int op = 0; op < 2; op++) begin
         host_req = 1'b1; host_we = (op == 0); host_addr = 19'h200; host_wdata = 12'hABC;
         accepted = 1'b0; tg = 0;
         for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge sys_clk);
            if (host_rdy) begin accepted = 1'b1; tg = cyc; end
            nextCycle;
         end
         host_req = 1'b0;
         compared++;
         if (!accepted) begin
            mismatched++;
            $display("[TB] FAIL host_accept op %0d: got no host_rdy expected acceptance", op);
         end
         if (op == 0) refMem[32'h200] = 12'hABC;
      end
      rvCyc = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         if (host_rvld && rvCyc < 0) begin
            rvCyc = cyc;
            compared++;
            if (host_rdata !== 12'hABC) begin
               mismatched++;
               $display("[TB] FAIL write_then_read: got %h expected abc", host_rdata);
            end
         end
         nextCycle;
      end
      compared++;
      if (rvCyc != tg + 2 + READ_LAT) begin
         mismatched++;
         $display("[TB] FAIL host_read_latency: got cycle %0d expected %0d", rvCyc, tg + 2 + READ_LAT);
      end
      compared++;
      if (streamWords != w0) begin
         mismatched++;
         $display("[TB] FAIL host_no_stream: got %0d words expected 0", streamWords - w0);
      end
   endtask

   task automatic test_back_to_back_host;
      int expCyc[$];
      logic [RGB_SIZE-1:0] expDat[$];
      bit expRv;
      int a;
      fetch_en = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (i < 60) begin
            a = 32'h3000 + int'($urandom_range(0, 7));
            host_req = 1'b1; host_we = $urandom_range(0, 1) != 0;
            host_addr = AW'(a); host_wdata = RGB_SIZE'($urandom);
         end else begin
            host_req = 1'b0;
         end
         @(negedge sys_clk);
         if (i < 60) begin
            compared++;
            if (host_rdy !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL host_b2b_rdy cycle %0d: got %b expected 1", cyc, host_rdy);
            end
            if (host_we) refMem[a] = host_wdata;
            else begin
               expCyc.push_back(cyc + 2 + READ_LAT);
               expDat.push_back(refRead(a));
            end
         end
         expRv = (expCyc.size() > 0) && (expCyc[0] == cyc);
         compared++;
         if (host_rvld !== expRv) begin
            mismatched++;
            $display("[TB] FAIL host_b2b_rvld cycle %0d: got %b expected %b", cyc, host_rvld, expRv);
         end
         if (expRv) begin
            void'(expCyc.pop_front());
            compared++;
            if (host_rdata !== expDat[0]) begin
               mismatched++;
               $display("[TB] FAIL host_b2b_rdata: got %h expected %h", host_rdata, expDat[0]);
            end
            void'(expDat.pop_front());
         end
         nextCycle;
      end
   endtask

   task automatic test_mid_reset;
      logic [31:0] obs [8];
      string nm [8];
      int stray, w0;
      fetch_en = 1'b0; line_buffer_rdy = 1'b0;
      host_we = 1'b0; host_addr = 19'h100; host_req = 1'b1;
      nextCycle;
      host_req = 1'b0; fetch_en = 1'b1;
      nextCycle;
      nextCycle;
      sys_rst = 1'b1; fetch_en = 1'b0; host_req = 1'b1;
      @(negedge sys_clk);
      compared++;
      if (host_rdy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rdy_during_reset: got %b expected 0", host_rdy);
      end
      nextCycle;
      @(negedge sys_clk);
      obs = '{32'(sram_ce), 32'(sram_we), 32'(sram_addr), 32'(sram_wdata),
              32'(host_rdy), 32'(host_rvld), 32'(host_rdata), 32'(line_buffer_vld)};
      nm  = '{"sram_ce", "sram_we", "sram_addr", "sram_wdata",
              "host_rdy", "host_rvld", "host_rdata", "line_buffer_vld"};
      for (int i = 0; i < 8; i++) begin
         compared++;
         if (obs[i] !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset %s: got %0h expected 0", nm[i], obs[i]);
         end
      end
      nextCycle;
      sys_rst = 1'b0; host_req = 1'b0; line_buffer_rdy = 1'b1;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (line_buffer_vld || host_rvld) stray++;
         nextCycle;
      end
      compared++;
      if (stray != 0) begin
         mismatched++;
         $display("[TB] FAIL stray_after_reset: got %0d cycles expected 0", stray);
      end
      expAddr = 0; w0 = streamWords;
      fetch_en = 1'b1;
      repeat (30) nextCycle;
      compared++;
      if (streamWords - w0 < 20) begin
         mismatched++;
         $display("[TB] FAIL restart_after_reset: got %0d words expected at least 20", streamWords - w0);
      end
      fetch_en = 1'b0;
      repeat (20) nextCycle;
   endtask

   initial begin
      seedMask = 12'($urandom);
      sys_rst = 1'b1; fetch_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
      host_addr = '0; host_wdata = '0; line_buffer_rdy = 1'b0;
      for (int i = 0; i < READ_LAT; i++) rdPipe[i] = '0;
      #1;
      test_reset;
      test_free_running;
      test_backpressure;
      test_fetch_disable;
      test_host_starvation;
      test_host_write_read;
      test_back_to_back_host;
      test_mid_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
